// File: rtl/entity_pkg.sv
// Shared constants and motion-state encoding for entity motion blocks.
package entity_pkg;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned ENTITY_W = 16;
  localparam int unsigned X_MAX_DEF = SCREEN_W - ENTITY_W;

  // Encoding is visible to software through motion_state.
  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWalk      = 2'd1,
    StKnockback = 2'd2
  } motion_state_e;

endpackage

// File: rtl/axis_clamp_step.sv
// Combinational single-axis step with clamping to [bound_min, bound_max].
// Shared between the x and y motion blocks.
module axis_clamp_step
  import entity_pkg::*;
#(
  parameter int unsigned W = COORD_W
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] step,
  input  logic         dir,        // 1 = toward bound_max, 0 = toward bound_min
  input  logic [W-1:0] bound_min,
  input  logic [W-1:0] bound_max,
  output logic [W-1:0] next_x
);

  logic signed [W:0] sum;

  // Signed sum with one extra bit so stepping below zero is detectable.
  always_comb begin
    if (dir) begin
      sum = $signed({1'b0, x}) + $signed({1'b0, step});
    end else begin
      sum = $signed({1'b0, x}) - $signed({1'b0, step});
    end
    if (sum < $signed({1'b0, bound_min})) begin
      next_x = bound_min;
    end else if (sum > $signed({1'b0, bound_max})) begin
      next_x = bound_max;
    end else begin
      next_x = sum[W-1:0];
    end
  end

endmodule

// File: rtl/entity_x_motion.sv
// Horizontal position of one entity, updated once per video frame from
// direction inputs, with hit-triggered knockback and playfield clamping.
module entity_x_motion
  import entity_pkg::*;
#(
  parameter int unsigned X_MIN     = 0,
  parameter int unsigned X_MAX     = X_MAX_DEF,
  parameter int unsigned X_RESET   = 320,
  parameter int unsigned WALK_STEP = 2,
  parameter int unsigned KB_STEP   = 4,
  parameter int unsigned KB_FRAMES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               move_left,
  input  logic               move_right,
  input  logic               hit,
  input  logic               hit_from_right,
  input  logic               freeze,
  output logic [COORD_W-1:0] entity_x,
  output logic               x_update,
  output logic [1:0]         motion_state
);

  motion_state_e      state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               dir_q, dir_d;     // 1 = struck from the right (push left)
  logic [COORD_W-1:0] x_q, x_d;
  logic               upd_q, upd_d;

  logic               tick_en;
  logic               push_left;
  logic [COORD_W-1:0] step;
  logic               step_up;
  logic [COORD_W-1:0] x_stepped;

  assign tick_en = frame_tick & ~freeze;
  // A hit coinciding with the consuming tick uses its own direction.
  assign push_left = hit ? hit_from_right : dir_q;

  // Motion decision: hit latch, knockback counter, state and step to apply.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q | hit;
    dir_d   = hit ? hit_from_right : dir_q;
    step    = '0;
    step_up = 1'b0;
    if (tick_en) begin
      if (pend_q || hit) begin
        state_d = StKnockback;
        cnt_d   = 4'(KB_FRAMES - 1);
        pend_d  = 1'b0;
        step    = COORD_W'(KB_STEP);
        step_up = ~push_left;
      end else if (state_q == StKnockback && cnt_q != 4'd0) begin
        cnt_d   = cnt_q - 4'd1;
        step    = COORD_W'(KB_STEP);
        step_up = ~dir_q;
      end else if (move_left ^ move_right) begin
        state_d = StWalk;
        step    = COORD_W'(WALK_STEP);
        step_up = move_right;
      end else begin
        state_d = StIdle;
      end
    end
  end

  axis_clamp_step #(
    .W (COORD_W)
  ) u_clamp (
    .x         (x_q),
    .step      (step),
    .dir       (step_up),
    .bound_min (COORD_W'(X_MIN)),
    .bound_max (COORD_W'(X_MAX)),
    .next_x    (x_stepped)
  );

  // Position only moves on an unfrozen tick; pulse when the value changed.
  always_comb begin
    x_d   = tick_en ? x_stepped : x_q;
    upd_d = tick_en && (x_stepped != x_q);
  end

  // State registers; reset also discards any pending hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      pend_q  <= 1'b0;
      dir_q   <= 1'b0;
      x_q     <= COORD_W'(X_RESET);
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      x_q     <= x_d;
      upd_q   <= upd_d;
    end
  end

  assign entity_x     = x_q;
  assign x_update     = upd_q;
  assign motion_state = state_q;

endmodule

// File: tb/tb_entity_x_motion.sv
// Self-checking bench for entity_x_motion: frame-level behavioural model,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_entity_x_motion;

  localparam int X_MIN_P = 0;
  localparam int X_MAX_P = 624;
  localparam int X_RST_P = 320;
  localparam int WALK_P  = 2;
  localparam int KB_P    = 4;
  localparam int KBF_P   = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick = 1'b0;
  logic       move_left = 1'b0;
  logic       move_right = 1'b0;
  logic       hit = 1'b0;
  logic       hit_from_right = 1'b0;
  logic       freeze = 1'b0;
  logic [9:0] entity_x;
  logic       x_update;
  logic [1:0] motion_state;

  int tests = 0;
  int fails = 0;

  entity_x_motion #(
    .X_MIN     (X_MIN_P),
    .X_MAX     (X_MAX_P),
    .X_RESET   (X_RST_P),
    .WALK_STEP (WALK_P),
    .KB_STEP   (KB_P),
    .KB_FRAMES (KBF_P)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .frame_tick     (frame_tick),
    .move_left      (move_left),
    .move_right     (move_right),
    .hit            (hit),
    .hit_from_right (hit_from_right),
    .freeze         (freeze),
    .entity_x       (entity_x),
    .x_update       (x_update),
    .motion_state   (motion_state)
  );

  always #5 clk = ~clk;

  // Behavioural model: frames of knockback remaining, pending hit, position.
  int m_x;
  int m_st;
  int m_upd;
  int m_pend;
  int m_pdir;
  int m_kb_left;
  int m_kdir;
  int m_nx;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_x = X_RST_P; m_st = 0; m_upd = 0; m_pend = 0; m_pdir = 0;
      m_kb_left = 0; m_kdir = 0;
    end else begin
      m_upd = 0;
      if (frame_tick && !freeze) begin
        if (m_pend != 0 || hit) begin
          m_kb_left = KBF_P;
          m_kdir = hit ? int'(hit_from_right) : m_pdir;
          m_pend = 0;
        end
        m_nx = m_x;
        if (m_kb_left > 0) begin
          m_nx = (m_kdir != 0) ? m_x - KB_P : m_x + KB_P;
          m_kb_left = m_kb_left - 1;
          m_st = 2;
        end else if (move_left != move_right) begin
          m_nx = move_right ? m_x + WALK_P : m_x - WALK_P;
          m_st = 1;
        end else begin
          m_st = 0;
        end
        if (m_nx < X_MIN_P) m_nx = X_MIN_P;
        if (m_nx > X_MAX_P) m_nx = X_MAX_P;
        m_upd = (m_nx != m_x) ? 1 : 0;
        m_x = m_nx;
      end else if (hit) begin
        m_pend = 1;
        m_pdir = int'(hit_from_right);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input int exp);
    tests++;
    if (act !== 32'(exp)) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    check("model_x", 32'(entity_x), m_x);
    check("model_upd", 32'(x_update), m_upd);
    check("model_state", 32'(motion_state), m_st);
  endtask

  // Compare at the falling edge, then drive the next cycle's inputs.
  task automatic drive(input logic r, ft, ml, mr, h, hr, fz);
    @(negedge clk);
    cmp_model();
    reset = r; frame_tick = ft; move_left = ml; move_right = mr;
    hit = h; hit_from_right = hr; freeze = fz;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick(input logic ml, mr);
    drive(0, 1, ml, mr, 0, 0, 0);
    drive(0, 0, ml, mr, 0, 0, 0);
  endtask

  task automatic tick_chk(input string name, input logic ml, mr,
                          input int ex, input int est, input int eupd);
    tick(ml, mr);
    check({name, "_x"}, 32'(entity_x), ex);
    check({name, "_state"}, 32'(motion_state), est);
    check({name, "_upd"}, 32'(x_update), eupd);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_x", 32'(entity_x), 320);
    check("reset_state", 32'(motion_state), 0);
    check("reset_upd", 32'(x_update), 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // Walk right three frames.
    for (int i = 0; i < 3; i++) tick_chk("walk_r", 0, 1, 322 + 2 * i, 1, 1);

    // Both then neither: no motion.
    do_reset();
    tick_chk("both", 1, 1, 320, 0, 0);
    tick_chk("neither", 0, 0, 320, 0, 0);

    // Knockback from the right for 8 frames, then walking resumes.
    do_reset();
    drive(0, 0, 0, 1, 1, 1, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) tick_chk("kb", 0, 1, 316 - 4 * i, 2, 1);
    tick_chk("kb_end", 0, 1, 290, 1, 1);

    // Left bound.
    do_reset();
    for (int i = 0; i < 159; i++) tick(1, 0);
    tick_chk("lo_reach", 1, 0, 0, 1, 1);
    tick_chk("lo_hold", 1, 0, 0, 1, 0);
    // Right bound.
    do_reset();
    for (int i = 0; i < 151; i++) tick(0, 1);
    tick_chk("hi_reach", 0, 1, 624, 1, 1);
    tick_chk("hi_hold", 0, 1, 624, 1, 0);
    // Knockback pushing into the bound keeps the knockback state.
    drive(0, 0, 0, 0, 1, 0, 0);
    tick_chk("kb_bound", 0, 0, 624, 2, 0);

    // Frozen tick with a hit: nothing moves, hit stays pending.
    do_reset();
    drive(0, 1, 0, 0, 1, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("frz_x", 32'(entity_x), 320);
    check("frz_state", 32'(motion_state), 0);
    for (int i = 0; i < 5; i++) tick_chk("kb1", 0, 0, 316 - 4 * i, 2, 1);
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) tick_chk("kb2", 0, 0, 304 + 4 * i, 2, 1);
    tick_chk("kb2_end", 0, 0, 332, 0, 0);

    // Asynchronous reset mid-knockback.
    do_reset();
    drive(0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) tick_chk("kb3", 0, 0, 316 - 4 * i, 2, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_x", 32'(entity_x), 320);
    check("async_state", 32'(motion_state), 0);
    check("async_upd", 32'(x_update), 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick_chk("post_rst", 1, 0, 318, 1, 1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      drive(logic'($urandom_range(0, 999) == 0),
            logic'($urandom_range(0, 3) == 0),
            logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 15) == 0),
            logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 7) == 0));
    end
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
